// File: rtl/stopwatch_pkg.sv
// Shared state encoding and sizing constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVF   = 2'b11
    } state_t;

    localparam int unsigned PRESCALE_DEFAULT = 50000;
    localparam int unsigned NDIG_MAX         = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Count-tick prescaler: advances while run, holds otherwise, zero forces it to 0.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam int unsigned W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || zero) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: prescaled tick, BCD carry-chain enables and run FSM.
// Optional lap-freeze flag is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned NDIG     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_stop,
    input  logic            lap_reset,
    input  logic [NDIG-1:0] co,
    output logic            inc,
    output logic            clr,
    output logic [NDIG-1:0] clk_en,
    output logic            tick,
    output logic [1:0]      state,
    output logic            lap_hold,
    output logic            ovf
);

    state_t st;
    logic   run;
    logic   zero;
    logic   tick_i;
    logic   sat;

    assign run  = (st == S_RUN);
    assign zero = (st == S_IDLE) || (st == S_OVF);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .zero (zero),
        .tick (tick_i)
    );

    assign tick = tick_i;
    // All digits at 9 on a tick: suppress every enable so the display saturates.
    assign sat  = tick_i && (&co);

    always_comb begin
        logic chain;
        clk_en = '0;
        chain  = tick_i && !sat;
        for (int unsigned i = 0; i < NDIG; i++) begin
            clk_en[i] = chain;
            chain     = chain && co[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= S_IDLE;
            clr <= 1'b0;
        end else begin
            clr <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (lap_reset) begin
                        clr <= 1'b1;
                    end else if (start_stop) begin
                        st <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (sat) begin
                        st <= S_OVF;
                    end else if (start_stop) begin
                        st <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (lap_reset) begin
                        clr <= 1'b1;
                        st  <= S_IDLE;
                    end else if (start_stop) begin
                        st <= S_RUN;
                    end
                end
                S_OVF: begin
                    if (lap_reset) begin
                        clr <= 1'b1;
                        st  <= S_IDLE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q <= 1'b0;
        end else begin
            case (st)
                S_RUN:          if (lap_reset && !start_stop) lap_q <= ~lap_q;
                S_PAUSE, S_OVF: if (lap_reset) lap_q <= 1'b0;
                default:        ;
            endcase
        end
    end

    assign lap_hold = lap_q;
`else
    assign lap_hold = 1'b0;
`endif

    assign state = st;
    assign inc   = (st == S_RUN);
    assign ovf   = (st == S_OVF);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with PRESCALE=4, NDIG=4 and a four-digit BCD counter model.
module tb_stopwatch_ctrl;

    localparam int unsigned NDIG = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_stop;
    logic            lap_reset;
    logic [NDIG-1:0] co;
    logic            inc;
    logic            clr;
    logic [NDIG-1:0] clk_en;
    logic            tick;
    logic [1:0]      state;
    logic            lap_hold;
    logic            ovf;

    logic            preload;
    logic [3:0]      dig [NDIG];
    logic [15:0]     digits;

    int unsigned     n_assert = 0;
    int unsigned     n_fail   = 0;

`ifdef STOPWATCH_LAP_EN
    localparam logic LAP_ON = 1'b1;
`else
    localparam logic LAP_ON = 1'b0;
`endif

    stopwatch_ctrl #(
        .PRESCALE(4),
        .NDIG    (NDIG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .lap_reset (lap_reset),
        .co        (co),
        .inc       (inc),
        .clr       (clr),
        .clk_en    (clk_en),
        .tick      (tick),
        .state     (state),
        .lap_hold  (lap_hold),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Mod-10 digit chain driven by the controller's enables
    always @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NDIG; i++) dig[i] <= 4'd0;
        end else if (preload) begin
            for (int i = 0; i < NDIG; i++) dig[i] <= 4'd9;
        end else begin
            for (int i = 0; i < NDIG; i++)
                if (clk_en[i]) dig[i] <= (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
        end
    end

    always_comb begin
        co = '0;
        for (int i = 0; i < NDIG; i++) co[i] = (dig[i] == 4'd9);
    end
    assign digits = {dig[3], dig[2], dig[1], dig[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ss, input logic lr);
        start_stop = ss;
        lap_reset  = lr;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
    endtask

    initial begin
        int ticks;
        int bad_phase;
        int en1_cnt;
        int en1_at;

        rst        = 1'b1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        preload    = 1'b0;
        cyc(2);

        // 1: reset state
        check("rst_state", 32'(state), 32'h0);
        check("rst_inc", 32'(inc), 32'h0);
        check("rst_clr", 32'(clr), 32'h0);
        check("rst_clk_en", 32'(clk_en), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_lap", 32'(lap_hold), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);

        // 2: start and count 40 cycles
        rst = 1'b0;
        pulse(1'b1, 1'b0);
        check("run_state", 32'(state), 32'h1);
        check("run_inc", 32'(inc), 32'h1);
        check("run_tick0", 32'(tick), 32'h0);
        ticks = 0; bad_phase = 0; en1_cnt = 0; en1_at = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (tick) begin
                ticks++;
                if (i % 4 != 3) bad_phase++;
            end
            if (clk_en[1]) begin
                en1_cnt++;
                en1_at = ticks;
            end
        end
        check("tick_count", 32'(ticks), 32'd10);
        check("tick_phase", 32'(bad_phase), 32'd0);
        check("en1_count", 32'(en1_cnt), 32'd1);
        check("en1_on_tick10", 32'(en1_at), 32'd10);
        check("digits_0010", 32'(digits), 32'h0010);

        // 3: pause with prescaler held at 2, then resume
        cyc(1);
        pulse(1'b1, 1'b0);
        check("pause_state", 32'(state), 32'h2);
        check("pause_inc", 32'(inc), 32'h0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (tick) ticks++;
        end
        check("pause_no_tick", 32'(ticks), 32'd0);
        check("pause_hold_state", 32'(state), 32'h2);
        pulse(1'b1, 1'b0);
        check("resume_state", 32'(state), 32'h1);
        check("resume_tick_c1", 32'(tick), 32'h0);
        cyc(1);
        check("resume_tick_c2", 32'(tick), 32'h1);
        cyc(1);
        check("digits_0011", 32'(digits), 32'h0011);

        // 4: saturation at 9999
        preload = 1'b1;
        cyc(1);
        preload = 1'b0;
        check("preload_9999", 32'(digits), 32'h9999);
        cyc(2);
        check("sat_tick", 32'(tick), 32'h1);
        check("sat_clk_en", 32'(clk_en), 32'h0);
        cyc(1);
        check("ovf_state", 32'(state), 32'h3);
        check("ovf_flag", 32'(ovf), 32'h1);
        check("ovf_inc", 32'(inc), 32'h0);
        check("ovf_digits", 32'(digits), 32'h9999);
        pulse(1'b1, 1'b0);
        check("ovf_ignore_ss", 32'(state), 32'h3);
        check("ovf_digits_hold", 32'(digits), 32'h9999);
        pulse(1'b0, 1'b1);
        check("ovf_clr_state", 32'(state), 32'h0);
        check("ovf_clr_pulse", 32'(clr), 32'h1);
        cyc(1);
        check("ovf_clr_drop", 32'(clr), 32'h0);
        check("ovf_digits_clr", 32'(digits), 32'h0000);

        // 5: simultaneous presses
        pulse(1'b1, 1'b0);
        check("s5_run", 32'(state), 32'h1);
        pulse(1'b1, 1'b0);
        check("s5_pause", 32'(state), 32'h2);
        pulse(1'b1, 1'b1);
        check("pause_both_state", 32'(state), 32'h0);
        check("pause_both_clr", 32'(clr), 32'h1);
        check("pause_both_lap", 32'(lap_hold), 32'h0);
        cyc(1);
        check("pause_both_clr_drop", 32'(clr), 32'h0);
        pulse(1'b1, 1'b0);
        check("s5_run2", 32'(state), 32'h1);
        pulse(1'b1, 1'b1);
        check("run_both_state", 32'(state), 32'h2);
        check("run_both_clr", 32'(clr), 32'h0);
        check("run_both_lap", 32'(lap_hold), 32'h0);

        // 6: lap toggle in RUN, then reset mid-run
        pulse(1'b1, 1'b0);
        check("s6_run", 32'(state), 32'h1);
        pulse(1'b0, 1'b1);
        check("lap_first", 32'(lap_hold), 32'(LAP_ON));
        check("lap_first_state", 32'(state), 32'h1);
        check("lap_first_clr", 32'(clr), 32'h0);
        pulse(1'b0, 1'b1);
        check("lap_second", 32'(lap_hold), 32'h0);
        check("lap_second_inc", 32'(inc), 32'h1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrun_rst_state", 32'(state), 32'h0);
        check("midrun_rst_inc", 32'(inc), 32'h0);
        check("midrun_rst_clr", 32'(clr), 32'h0);
        check("midrun_rst_tick", 32'(tick), 32'h0);
        pulse(1'b1, 1'b0);
        check("restart_state", 32'(state), 32'h1);
        check("restart_tick_c1", 32'(tick), 32'h0);
        cyc(1);
        check("restart_tick_c2", 32'(tick), 32'h0);
        cyc(1);
        check("restart_tick_c3", 32'(tick), 32'h0);
        cyc(1);
        check("restart_tick_c4", 32'(tick), 32'h1);
        check("restart_clk_en", 32'(clk_en), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for a chain of NDIG cascaded mod-10 BCD digit counters (digit 0 = least significant) that form a stopwatch.
- Generates a prescaled count tick and the per-digit clock enables from digit carries.
- Drives the shared inc/clr controls and runs the start/stop/pause/lap/reset FSM from two debounced single-cycle button pulses.
- Sits between the button conditioning logic and the digit counter chain; a display path consumes lap_hold.

Parameters:
- PRESCALE, 50000: clk cycles per count tick (≥2).
- NDIG, 4: number of cascaded BCD digits (1..8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_stop  in  1  debounced single-cycle pulse.
- lap_reset  in  1  debounced single-cycle pulse.
- co  in  NDIG  carry-outs of the digit counters (co[i]=1 when digit i reads 9).
- inc  out  1  count-enable level to all digits.
- clr  out  1  registered one-cycle clear pulse to all digits.
- clk_en  out  NDIG  per-digit clock enable (combinational).
- tick  out  1  prescaler tick (combinational).
- state  out  2  FSM state encoding.
- lap_hold  out  1  display-freeze flag.
- ovf  out  1  high while in OVF.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, prescaler=0, clr=0, lap_hold=0. Consequently inc=0, tick=0, clk_en=0, ovf=0. rst overrides all inputs, including mid-RUN.
- States: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, OVF=2'b11. inc=1 only in RUN; ovf=1 only in OVF.
- Prescaler, width clog2(PRESCALE):
  - Counts only in RUN and wraps PRESCALE-1→0.
  - Holds its value in PAUSE.
  - Is zeroed on entry to RUN from IDLE and in IDLE/OVF.
- tick = RUN && prescaler==PRESCALE-1.
- Carry chain: clk_en[0]=tick; clk_en[i]=tick && &co[i-1:0].
- Saturation: if tick && &co (display all 9s), clk_en is forced to 0 that cycle and the next state is OVF. Digits hold 9…9 and never wrap.
- IDLE:
  - lap_reset → clr pulse next cycle, stay IDLE.
  - else start_stop → RUN.
- RUN:
  - start_stop → PAUSE; start_stop has priority over a simultaneous lap_reset, which is then dropped.
  - lap_reset alone → toggle lap_hold; counting continues.
  - tick && &co → OVF.
- PAUSE:
  - lap_reset → clr pulse, lap_hold←0, → IDLE; has priority over start_stop.
  - else start_stop → RUN, prescaler resumes from its held value.
- OVF:
  - lap_reset → clr pulse, lap_hold←0, → IDLE.
  - start_stop is ignored.
- clr is registered: asserted exactly one cycle, the cycle after the accepted lap_reset edge, then deasserts. Never asserted from rst; the digits share rst directly.
- co is sampled combinationally. The counters update co one cycle after clk_en, so carries propagate correctly on the next tick.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: lap_reset in RUN toggles lap_hold as above.
- Undefined:
  - lap_hold is tied to 0 and its register is not built.
  - lap_reset in RUN is ignored.
  - lap_reset keeps its clear behaviour in IDLE, PAUSE and OVF.

Decomposition:
- Package stopwatch_pkg:
  - State encoding constants S_IDLE, S_RUN, S_PAUSE, S_OVF.
  - Default PRESCALE.
  - NDIG limit.
- One sub-module, tick_prescaler:
  - Inputs: clk, rst, run, zero.
  - Output: tick.
  - PRESCALE parameter.
- Carry-chain enables and FSM stay in stopwatch_ctrl.

Test Plan (PRESCALE=4, NDIG=4, bench models four mod-10 digits):
1. rst pulse → next edge state=00, inc=0, clr=0, clk_en=0000, lap_hold=0, ovf=0.
2. start_stop, run 40 cycles → tick every 4th cycle, 10 ticks, digits read 0010, clk_en[1]=1 exactly on the 10th tick.
3. start_stop when prescaler=2 → PAUSE, no tick for 20 cycles; start_stop → RUN, first tick 2 cycles after resume.
4. Preload digits 9999 in RUN → next tick has clk_en=0000, state=11, ovf=1, digits stay 9999; start_stop ignored; lap_reset → clr=1 for exactly one cycle, state=00.
5. In PAUSE, start_stop and lap_reset same cycle → clr pulse, state=IDLE, lap_hold=0. In RUN, both together → PAUSE, lap_hold unchanged.
6. With STOPWATCH_LAP_EN: lap_reset in RUN → lap_hold=1, counting continues; again → lap_hold=0. Without it, lap_hold stays 0. rst mid-RUN → IDLE, prescaler=0, next start_stop tick after 4 cycles.
